// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR stream descrambler: each accepted word is XORed with the low
// WIDTH bits of a 16-bit Fibonacci LFSR that runs in lock-step with the transmitter.
module xor_stream_descrambler #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [15:0]      SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic [15:0]       seed_in,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       word_count
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [15:0]       count_q, count_d;
  logic              accept;
  logic              drain;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign out_valid  = (state_q == ST_FULL);
  assign out_data   = data_q;
  assign word_count = count_q;

  // init blocks acceptance so a word offered alongside it is held upstream.
  assign in_ready = ~init & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    count_d = count_q;

    if (init) begin
      lfsr_d  = (seed_in == 16'h0000) ? SEED : seed_in;
      state_d = ST_EMPTY;
      count_d = 16'h0000;
    end else if (accept) begin
      data_d  = in_data ^ lfsr_q[WIDTH-1:0];
      state_d = ST_FULL;
      lfsr_d  = lfsr_step(lfsr_q);
      count_d = count_q + 16'd1;
    end else if (drain) begin
      // out_data keeps its last value once drained.
      state_d = ST_EMPTY;
    end
  end

  // NOTE: non-blocking assignments keep all state updating together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      lfsr_q  <= SEED;
      data_q  <= '0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Directed bench for xor_stream_descrambler: keystream values, inverse property,
// backpressure, init resync, async reset, counter wrap and a WIDTH=8 instance.
module tb_xor_stream_descrambler;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic [15:0] seed_in;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] word_count;

  logic [7:0]  in_data8;
  logic        in_ready8;
  logic [7:0]  out_data8;
  logic        out_valid8;
  logic [15:0] word_count8;

  int pass_cnt = 0;
  int total_cnt = 0;

  xor_stream_descrambler #(.WIDTH(16), .SEED(16'hACE1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .seed_in    (seed_in),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
  );

  xor_stream_descrambler #(.WIDTH(8), .SEED(16'hACE1)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .seed_in    (seed_in),
    .in_data    (in_data8),
    .in_valid   (in_valid),
    .in_ready   (in_ready8),
    .out_data   (out_data8),
    .out_valid  (out_valid8),
    .out_ready  (out_ready),
    .word_count (word_count8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference scrambler keystream step.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    init      = 1'b0;
    seed_in   = 16'h0000;
    out_ready = 1'b1;
    in_data   = 16'h0000;
    in_data8  = 8'h00;
    rst_n     = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    init      = 1'b0;
    seed_in   = 16'h0000;
    out_ready = 1'b1;
    in_data   = 16'h0000;
    in_data8  = 8'h00;
    rst_n     = 1'b0;
    #3;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (word_count !== 16'h0000) $display("FAIL reset_word_count: got %h expected 0000", word_count);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 16'h0000) $display("FAIL reset_out_data: got %h expected 0000", out_data);
    else pass_cnt++;
    #4;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_known_words();
    logic [15:0] exp16 [3];
    logic [7:0]  exp8 [3];
    exp16[0] = 16'hACE1; exp16[1] = 16'h59C3; exp16[2] = 16'hB387;
    exp8[0]  = 8'hE1;    exp8[1]  = 8'hC3;    exp8[2]  = 8'h87;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    in_data8 = 8'h00;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL known_pre_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp16[i])
        $display("FAIL known_word%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp16[i]);
      else pass_cnt++;
      total_cnt++;
      if (out_data8 !== exp8[i])
        $display("FAIL width8_word%0d: got %h expected %h", i, out_data8, exp8[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    total_cnt++;
    if (word_count !== 16'd3) $display("FAIL known_count: got %h expected 0003", word_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0 || out_data !== 16'hB387)
      $display("FAIL known_drain: got v=%b d=%h expected v=0 d=b387", out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_inverse();
    logic [15:0] ks;
    logic [15:0] plain;
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'hACE1;
    tick();
    total_cnt++;
    if (out_data !== 16'h0000) $display("FAIL inverse_seed: got %h expected 0000", out_data);
    else pass_cnt++;
    ks = ref_step(16'hACE1);
    for (int i = 0; i < 1000; i++) begin
      plain   = 16'($urandom);
      in_data = plain ^ ks;
      ks      = ref_step(ks);
      tick();
      total_cnt++;
      if (out_data !== plain || out_valid !== 1'b1)
        $display("FAIL inverse_word%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, plain);
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (out_data !== 16'hACE1 || out_valid !== 1'b1 || in_ready !== 1'b0 || word_count !== 16'd1)
        $display("FAIL stall_cycle%0d: got d=%h v=%b rdy=%b cnt=%h expected d=ace1 v=1 rdy=0 cnt=0001",
                 i, out_data, out_valid, in_ready, word_count);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_data !== 16'h59C3 || word_count !== 16'd2)
      $display("FAIL stall_after: got d=%h cnt=%h expected d=59c3 cnt=0002", out_data, word_count);
    else pass_cnt++;
  endtask

  task automatic test_init();
    // out_valid is 1 from the previous task; offer a word alongside init.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    init      = 1'b1;
    seed_in   = 16'h1234;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL init_in_ready: got %b expected 0", in_ready);
    else pass_cnt++;
    tick();
    init     = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b0 || word_count !== 16'h0000)
      $display("FAIL init_clear: got v=%b cnt=%h expected v=0 cnt=0000", out_valid, word_count);
    else pass_cnt++;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_data !== 16'h1234 || word_count !== 16'd1)
      $display("FAIL init_seed: got d=%h cnt=%h expected d=1234 cnt=0001", out_data, word_count);
    else pass_cnt++;
    init    = 1'b1;
    seed_in = 16'h0000;
    tick();
    init     = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_data !== 16'hACE1) $display("FAIL init_zero_seed: got %h expected ace1", out_data);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || word_count !== 16'h0000)
      $display("FAIL async_reset: got v=%b cnt=%h expected v=0 cnt=0000", out_valid, word_count);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_data !== 16'hACE1 || out_valid !== 1'b1)
      $display("FAIL async_reset_resume: got d=%h v=%b expected d=ace1 v=1", out_data, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_count_wrap();
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    repeat (65535) @(posedge clk);
    #1;
    total_cnt++;
    if (word_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %h expected ffff", word_count);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (word_count !== 16'h0000) $display("FAIL wrap_zero: got %h expected 0000", word_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_known_words();
    test_inverse();
    test_back_to_back_stall();
    test_init();
    test_async_reset();
    test_count_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
